// File: rtl/alu_pkg.sv
// Shared ALU/decode definitions: ALU operation codes, RV32I major opcodes,
// operand-select encodings and the decoded bundle carried by the decode stage.
package alu_pkg;

   localparam int XLEN = 32;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_NOT  = 4'b0010;
   localparam logic [3:0] ALU_SLL  = 4'b0011;
   localparam logic [3:0] ALU_SRL  = 4'b0100;
   localparam logic [3:0] ALU_AND  = 4'b0101;
   localparam logic [3:0] ALU_OR   = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_SLTU = 4'b1001;
   localparam logic [3:0] ALU_XOR  = 4'b1010;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [1:0] A_RS1  = 2'b00;
   localparam logic [1:0] A_PC   = 2'b01;
   localparam logic [1:0] A_ZERO = 2'b10;

   localparam logic B_RS2 = 1'b0;
   localparam logic B_IMM = 1'b1;

   typedef struct packed {
      logic [3:0]      alu_ctl;
      logic [1:0]      a_sel;
      logic            b_sel;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [XLEN-1:0] imm;
      logic            reg_write;
      logic            illegal;
   } dec_t;

   // Shared funct3 mapping for OP and OP-IMM; SUB and shift legality are handled by the caller.
   function automatic logic [3:0] alu_from_funct3(input logic [2:0] funct3);
      logic [3:0] code;
      case (funct3)
         3'b000:  code = ALU_ADD;
         3'b001:  code = ALU_SLL;
         3'b010:  code = ALU_SLT;
         3'b011:  code = ALU_SLTU;
         3'b100:  code = ALU_XOR;
         3'b101:  code = ALU_SRL;
         3'b110:  code = ALU_OR;
         default: code = ALU_AND;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/alu_decode_comb.sv
// Combinational RV32I instruction -> ALU control bundle decoder.
// Latency: none (pure logic); no flow control of its own.
module alu_decode_comb
   import alu_pkg::*;
(
   input  logic [XLEN-1:0] instr,
   output dec_t            dec
);

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic [XLEN-1:0] imm_i;
   logic [XLEN-1:0] imm_s;
   logic [XLEN-1:0] imm_b;
   logic [XLEN-1:0] imm_u;
   logic [XLEN-1:0] imm_j;
   logic [XLEN-1:0] imm_sh;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];

   assign imm_i  = {{20{instr[31]}}, instr[31:20]};
   assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u  = {instr[31:12], 12'b0};
   assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
   assign imm_sh = {27'b0, instr[24:20]};

   always_comb begin
      dec           = '0;
      dec.rs1       = instr[19:15];
      dec.rs2       = instr[24:20];
      dec.rd        = instr[11:7];
      dec.alu_ctl   = ALU_ADD;
      dec.a_sel     = A_RS1;
      dec.b_sel     = B_IMM;
      dec.imm       = imm_i;
      dec.reg_write = 1'b0;
      dec.illegal   = 1'b0;

      case (opcode)
         OPC_OP: begin
            dec.b_sel     = B_RS2;
            dec.imm       = '0;
            dec.reg_write = 1'b1;
            dec.alu_ctl   = alu_from_funct3(funct3);
            if (funct7 == 7'b0100000 && funct3 == 3'b000)
               dec.alu_ctl = ALU_SUB;
            else if (funct7 != 7'b0000000)
               dec.illegal = 1'b1;
         end
         OPC_OP_IMM: begin
            dec.reg_write = 1'b1;
            dec.alu_ctl   = alu_from_funct3(funct3);
            // No arithmetic right shift in the ALU, so SRAI falls out as illegal here.
            if (funct3 == 3'b001 || funct3 == 3'b101) begin
               dec.imm = imm_sh;
               if (funct7 != 7'b0000000)
                  dec.illegal = 1'b1;
            end
         end
         OPC_LOAD, OPC_JALR: begin
            dec.reg_write = 1'b1;
         end
         OPC_STORE: begin
            dec.imm = imm_s;
         end
         OPC_BRANCH: begin
            dec.b_sel = B_RS2;
            dec.imm   = imm_b;
            case (funct3[2:1])
               2'b00:   dec.alu_ctl = ALU_SUB;
               2'b10:   dec.alu_ctl = ALU_SLT;
               2'b11:   dec.alu_ctl = ALU_SLTU;
               default: dec.illegal = 1'b1;
            endcase
         end
         OPC_LUI: begin
            dec.a_sel     = A_ZERO;
            dec.imm       = imm_u;
            dec.reg_write = 1'b1;
         end
         OPC_AUIPC: begin
            dec.a_sel     = A_PC;
            dec.imm       = imm_u;
            dec.reg_write = 1'b1;
         end
         OPC_JAL: begin
            dec.a_sel     = A_PC;
            dec.imm       = imm_j;
            dec.reg_write = 1'b1;
         end
         default: begin
            dec.illegal = 1'b1;
         end
      endcase

      if (dec.illegal) begin
         dec.alu_ctl   = ALU_ADD;
         dec.reg_write = 1'b0;
      end
      if (dec.rd == 5'd0)
         dec.reg_write = 1'b0;
   end

endmodule

// File: rtl/alu_decode.sv
// Registered RV32I decode stage: one output register, 1-cycle latency.
// Backpressure: in_ready = !out_valid || out_ready; bundle held stable while stalled.
module alu_decode
   import alu_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [3:0]      out_alu_ctl,
   output logic [1:0]      out_a_sel,
   output logic            out_b_sel,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [4:0]      out_rd,
   output logic [XLEN-1:0] out_imm,
   output logic            out_reg_write,
   output logic            out_illegal,
   output logic [XLEN-1:0] out_pc
);

   dec_t            dec_nxt;
   dec_t            dec_q;
   logic [XLEN-1:0] pc_q;
   logic            accept;

   alu_decode_comb u_comb (
      .instr (in_instr),
      .dec   (dec_nxt)
   );

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   // Flush wins over a same-cycle accept; the incoming word is dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         dec_q     <= '0;
         pc_q      <= '0;
      end else begin
         if (flush)
            out_valid <= 1'b0;
         else if (accept)
            out_valid <= 1'b1;
         else if (out_ready)
            out_valid <= 1'b0;

         if (accept && !flush) begin
            dec_q <= dec_nxt;
            pc_q  <= in_pc;
         end
      end
   end

   assign out_alu_ctl   = dec_q.alu_ctl;
   assign out_a_sel     = dec_q.a_sel;
   assign out_b_sel     = dec_q.b_sel;
   assign out_rs1       = dec_q.rs1;
   assign out_rs2       = dec_q.rs2;
   assign out_rd        = dec_q.rd;
   assign out_imm       = dec_q.imm;
   assign out_reg_write = dec_q.reg_write;
   assign out_illegal   = dec_q.illegal;
   assign out_pc        = pc_q;

endmodule

// File: tb/tb_alu_decode.sv
// Bench for alu_decode: directed vector table, handshake corner sequences,
// then a randomized stream scored against a behavioural decode model.
module tb_alu_decode;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_alu_ctl;
   logic [1:0]  out_a_sel;
   logic        out_b_sel;
   logic [4:0]  out_rs1;
   logic [4:0]  out_rs2;
   logic [4:0]  out_rd;
   logic [31:0] out_imm;
   logic        out_reg_write;
   logic        out_illegal;
   logic [31:0] out_pc;

   typedef struct {
      logic [3:0]  alu;
      logic [1:0]  a;
      logic        b;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        rw;
      logic        ill;
   } exp_t;

   typedef struct {
      logic [31:0] instr;
      exp_t        e;
   } vec_t;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } txn_t;

   // funct3 -> ALU code for OP/OP-IMM: ADD SLL SLT SLTU XOR SRL OR AND
   localparam logic [3:0] F3MAP [8] = '{4'h0, 4'h3, 4'h7, 4'h9, 4'hA, 4'h4, 4'h6, 4'h5};

   int tests = 0;
   int fails = 0;

   alu_decode dut (
      .clk           (clk),
      .rst           (rst),
      .flush         (flush),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_instr      (in_instr),
      .in_pc         (in_pc),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_alu_ctl   (out_alu_ctl),
      .out_a_sel     (out_a_sel),
      .out_b_sel     (out_b_sel),
      .out_rs1       (out_rs1),
      .out_rs2       (out_rs2),
      .out_rd        (out_rd),
      .out_imm       (out_imm),
      .out_reg_write (out_reg_write),
      .out_illegal   (out_illegal),
      .out_pc        (out_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic chk_bundle(input string tag, input exp_t e, input logic [31:0] pc);
      chk({tag, ".alu_ctl"},   32'(out_alu_ctl),   32'(e.alu));
      chk({tag, ".a_sel"},     32'(out_a_sel),     32'(e.a));
      chk({tag, ".b_sel"},     32'(out_b_sel),     32'(e.b));
      chk({tag, ".imm"},       out_imm,            e.imm);
      chk({tag, ".rs1"},       32'(out_rs1),       32'(e.rs1));
      chk({tag, ".rs2"},       32'(out_rs2),       32'(e.rs2));
      chk({tag, ".rd"},        32'(out_rd),        32'(e.rd));
      chk({tag, ".reg_write"}, 32'(out_reg_write), 32'(e.rw));
      chk({tag, ".illegal"},   32'(out_illegal),   32'(e.ill));
      chk({tag, ".pc"},        out_pc,             pc);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
      chk_bundle(tag, '{4'h0, 2'd0, 1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0}, 32'h0);
   endtask

   // Reference decode built from the instruction-set rules using arithmetic shifts.
   function automatic exp_t ref_decode(input logic [31:0] i);
      exp_t               e;
      logic signed [31:0] s;
      logic [6:0]         op;
      logic [2:0]         f3;
      logic [6:0]         f7;
      s     = i;
      op    = i[6:0];
      f3    = i[14:12];
      f7    = i[31:25];
      e.rs1 = i[19:15];
      e.rs2 = i[24:20];
      e.rd  = i[11:7];
      e.alu = 4'h0;
      e.a   = 2'd0;
      e.b   = 1'b1;
      e.imm = 32'(s >>> 20);
      e.rw  = 1'b0;
      e.ill = 1'b0;
      case (op)
         7'h33: begin
            e.b   = 1'b0;
            e.imm = 32'h0;
            e.rw  = 1'b1;
            e.alu = F3MAP[f3];
            if (f3 == 3'd0 && f7 == 7'h20) e.alu = 4'h1;
            e.ill = !((f7 == 7'h00) || (f7 == 7'h20 && f3 == 3'd0));
         end
         7'h13: begin
            e.rw  = 1'b1;
            e.alu = F3MAP[f3];
            if (f3 == 3'd1 || f3 == 3'd5) begin
               e.imm = 32'(i[24:20]);
               e.ill = (f7 != 7'h00);
            end
         end
         7'h03, 7'h67: e.rw = 1'b1;
         7'h23: e.imm = 32'((s >>> 25) << 5) | 32'(i[11:7]);
         7'h63: begin
            e.b   = 1'b0;
            e.imm = 32'((s >>> 31) << 12) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
            if (f3 == 3'd0 || f3 == 3'd1)      e.alu = 4'h1;
            else if (f3 == 3'd4 || f3 == 3'd5) e.alu = 4'h7;
            else if (f3 == 3'd6 || f3 == 3'd7) e.alu = 4'h9;
            else                               e.ill = 1'b1;
         end
         7'h37: begin e.a = 2'd2; e.imm = i & 32'hFFFFF000; e.rw = 1'b1; end
         7'h17: begin e.a = 2'd1; e.imm = i & 32'hFFFFF000; e.rw = 1'b1; end
         7'h6F: begin
            e.a   = 2'd1;
            e.imm = 32'((s >>> 31) << 20) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
            e.rw  = 1'b1;
         end
         default: e.ill = 1'b1;
      endcase
      if (e.ill) begin e.alu = 4'h0; e.rw = 1'b0; end
      if (e.rd == 5'd0) e.rw = 1'b0;
      return e;
   endfunction

   function automatic logic [31:0] gen_instr();
      logic [6:0]  ops [9];
      logic [31:0] r;
      int          k;
      ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67, 7'h6F, 7'h37, 7'h17};
      r   = $urandom;
      k   = $urandom_range(0, 9);
      case ($urandom_range(0, 2))
         0:       r[31:25] = 7'h00;
         1:       r[31:25] = 7'h20;
         default: ;
      endcase
      if (k < 9) r[6:0] = ops[k];
      return r;
   endfunction

   vec_t        tbl [14];
   logic [31:0] seq_ins [3];
   logic [31:0] seq_pc  [3];
   logic        rpat    [8];
   logic [31:0] got [$];
   txn_t        q [$];

   initial begin
      tbl[0]  = '{32'h002081B3, '{4'h0, 2'd0, 1'b0, 32'h00000000, 5'd1,  5'd2,  5'd3, 1'b1, 1'b0}};
      tbl[1]  = '{32'h402081B3, '{4'h1, 2'd0, 1'b0, 32'h00000000, 5'd1,  5'd2,  5'd3, 1'b1, 1'b0}};
      tbl[2]  = '{32'hFFF00093, '{4'h0, 2'd0, 1'b1, 32'hFFFFFFFF, 5'd0,  5'd31, 5'd1, 1'b1, 1'b0}};
      tbl[3]  = '{32'h0020E463, '{4'h9, 2'd0, 1'b0, 32'h00000008, 5'd1,  5'd2,  5'd8, 1'b0, 1'b0}};
      tbl[4]  = '{32'h4010D093, '{4'h0, 2'd0, 1'b1, 32'h00000001, 5'd1,  5'd1,  5'd1, 1'b0, 1'b1}};
      tbl[5]  = '{32'h0000007F, '{4'h0, 2'd0, 1'b1, 32'h00000000, 5'd0,  5'd0,  5'd0, 1'b0, 1'b1}};
      tbl[6]  = '{32'h123452B7, '{4'h0, 2'd2, 1'b1, 32'h12345000, 5'd8,  5'd3,  5'd5, 1'b1, 1'b0}};
      tbl[7]  = '{32'hFFDFF0EF, '{4'h0, 2'd1, 1'b1, 32'hFFFFFFFC, 5'd31, 5'd29, 5'd1, 1'b1, 1'b0}};
      tbl[8]  = '{32'h0020A423, '{4'h0, 2'd0, 1'b1, 32'h00000008, 5'd1,  5'd2,  5'd8, 1'b0, 1'b0}};
      tbl[9]  = '{32'h00208033, '{4'h0, 2'd0, 1'b0, 32'h00000000, 5'd1,  5'd2,  5'd0, 1'b0, 1'b0}};
      tbl[10] = '{32'h0020A063, '{4'h0, 2'd0, 1'b0, 32'h00000000, 5'd1,  5'd2,  5'd0, 1'b0, 1'b1}};
      tbl[11] = '{32'h00001097, '{4'h0, 2'd1, 1'b1, 32'h00001000, 5'd0,  5'd0,  5'd1, 1'b1, 1'b0}};
      tbl[12] = '{32'h01F09093, '{4'h3, 2'd0, 1'b1, 32'h0000001F, 5'd1,  5'd31, 5'd1, 1'b1, 1'b0}};
      tbl[13] = '{32'h0020D063, '{4'h7, 2'd0, 1'b0, 32'h00000000, 5'd1,  5'd2,  5'd0, 1'b0, 1'b0}};

      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_instr  = 32'h0;
      in_pc     = 32'h0;
      out_ready = 1'b1;

      // Reset values, held across clock edges while reset is asserted.
      #12;
      chk_reset_vals("reset_a");
      @(negedge clk);
      #1;
      chk_reset_vals("reset_b");
      @(negedge clk);
      rst = 1'b0;

      // Directed vectors, one instruction each with the sink always ready.
      for (int k = 0; k < 14; k++) begin
         @(negedge clk);
         in_valid  = 1'b1;
         in_instr  = tbl[k].instr;
         in_pc     = 32'h100 + 32'(k) * 4;
         out_ready = 1'b1;
         @(negedge clk);
         in_valid = 1'b0;
         #1;
         chk($sformatf("vec%0d.out_valid", k), 32'(out_valid), 32'd1);
         chk_bundle($sformatf("vec%0d", k), tbl[k].e, 32'h100 + 32'(k) * 4);
      end

      // Back-to-back stream with a two-cycle sink stall.
      seq_ins = '{32'h002081B3, 32'h402081B3, 32'hFFF00093};
      seq_pc  = '{32'h2000, 32'h2004, 32'h2008};
      rpat    = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      begin
         int          idx;
         logic        prev_stall;
         logic [31:0] prev_pc;
         logic [31:0] prev_imm;
         idx        = 0;
         prev_stall = 1'b0;
         prev_pc    = 32'h0;
         prev_imm   = 32'h0;
         for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            in_valid  = (idx < 3);
            if (idx < 3) begin
               in_instr = seq_ins[idx];
               in_pc    = seq_pc[idx];
            end
            out_ready = rpat[c];
            #1;
            if (out_valid && !out_ready) begin
               chk($sformatf("stall%0d.in_ready", c), 32'(in_ready), 32'd0);
               if (prev_stall) begin
                  chk($sformatf("stall%0d.frozen_pc", c), out_pc, prev_pc);
                  chk($sformatf("stall%0d.frozen_imm", c), out_imm, prev_imm);
               end
            end
            if (out_valid && out_ready) got.push_back(out_pc);
            if (in_valid && in_ready) idx++;
            prev_stall = out_valid && !out_ready;
            prev_pc    = out_pc;
            prev_imm   = out_imm;
         end
         in_valid  = 1'b0;
         out_ready = 1'b1;
         chk("stream.count", 32'(got.size()), 32'd3);
         for (int k = 0; k < 3; k++)
            chk($sformatf("stream.order%0d", k), (k < got.size()) ? got[k] : 32'hDEAD_DEAD, seq_pc[k]);
      end

      // Flush with a valid incoming instruction.
      @(negedge clk);
      in_valid = 1'b1;
      in_instr = 32'h002081B3;
      in_pc    = 32'h3000;
      @(negedge clk);
      in_instr = 32'h402081B3;
      in_pc    = 32'h3004;
      flush    = 1'b1;
      #1;
      chk("flush.in_ready", 32'(in_ready), 32'd1);
      chk("flush.held_valid", 32'(out_valid), 32'd1);
      @(negedge clk);
      flush    = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("flush.out_valid", 32'(out_valid), 32'd0);

      // Asynchronous reset while a bundle is held.
      @(negedge clk);
      in_valid  = 1'b1;
      in_instr  = 32'hFFF00093;
      in_pc     = 32'h4000;
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #1;
      chk("areset.pre_valid", 32'(out_valid), 32'd1);
      #1;
      rst = 1'b1;
      #1;
      chk_reset_vals("areset");
      @(negedge clk);
      rst       = 1'b0;
      out_ready = 1'b1;

      // First accept after reset happens on the first edge with in_valid.
      in_valid = 1'b1;
      in_instr = 32'h0020E463;
      in_pc    = 32'h5000;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("post_reset.out_valid", 32'(out_valid), 32'd1);
      chk_bundle("post_reset", ref_decode(32'h0020E463), 32'h5000);

      // Randomized stream against the transaction-level model.
      @(negedge clk);
      q.delete();
      for (int c = 0; c < 3000; c++) begin
         logic acc;
         @(negedge clk);
         in_valid  = ($urandom_range(0, 3) != 0);
         in_instr  = gen_instr();
         in_pc     = $urandom;
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 19) == 0);
         #1;
         chk("rand.in_ready", 32'(in_ready), 32'(q.size() == 0 || out_ready));
         chk("rand.out_valid", 32'(out_valid), 32'(q.size() != 0));
         if (q.size() != 0) chk_bundle("rand", ref_decode(q[0].instr), q[0].pc);
         acc = in_valid && (q.size() == 0 || out_ready);
         if (flush) begin
            q.delete();
         end else begin
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            if (acc) q.push_back('{in_instr, in_pc});
         end
      end
      flush    = 1'b0;
      in_valid = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/alu_decode.md
# alu_decode

Registered decode stage producing the `alu_ctl` code and operand selects consumed by the core's 32-bit ALU. It accepts one RV32I instruction per cycle over a valid/ready handshake. It decodes opcode/funct3/funct7 into the ALU's 4-bit operation encoding, generates the sign-extended immediate and flags unsupported encodings. It sits between fetch and register-read/execute, and holds one instruction in a single output pipeline register.

## Interface
- `XLEN`, 32: instruction, PC and immediate width; fixed at 32.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `flush` input 1: synchronous kill of the held instruction.
- `in_valid` input 1: `in_instr`/`in_pc` are valid.
- `in_ready` output 1: stage can accept this cycle.
- `in_instr` input 32: raw instruction word.
- `in_pc` input 32: PC of `in_instr`.
- `out_valid` output 1: decoded bundle valid.
- `out_ready` input 1: downstream accepts bundle.
- `out_alu_ctl` output 4: ALU operation code.
- `out_a_sel` output 2: ALU A operand select; 00 rs1, 01 pc, 10 zero.
- `out_b_sel` output 1: ALU B operand select; 0 rs2, 1 imm.
- `out_rs1`, `out_rs2`, `out_rd` output 5 each: register indices.
- `out_imm` output 32: sign-extended immediate.
- `out_reg_write` output 1: instruction writes `rd`; forced 0 when `rd`=0.
- `out_illegal` output 1: unsupported or unknown encoding.
- `out_pc` output 32: PC passed through.

## Operation
- ALU codes: ADD 0000, SUB 0001, NOT 0010, SLL 0011, SRL 0100, AND 0101, OR 0110, SLT 0111, SLTU 1001, XOR 1010.
- OP (0110011) and OP-IMM (0010011) map funct3 as follows: 000 ADD (SUB if OP with funct7=0100000), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
- SRA/SRAI (funct3 101, funct7 0100000) are illegal because the ALU has no arithmetic right shift.
- Any other funct7 on OP, or any funct7 other than 0000000 on SLLI/SRLI, is illegal.
- Per-class encoding:
  - LOAD, STORE, JALR: ADD, a=rs1, b=imm.
  - LUI: ADD, a=zero, b=imm.
  - AUIPC: ADD, a=pc, b=imm.
  - JAL: ADD, a=pc, b=imm; `reg_write`=1 (link value produced downstream).
  - BRANCH BEQ/BNE: SUB. BLT/BGE: SLT. BLTU/BGEU: SLTU. All with a=rs1, b=rs2, `reg_write`=0.
  - BRANCH funct3 010/011 is illegal.
- Immediate formats, all sign-extended from instr[31]:
  - I: LOAD/OP-IMM/JALR.
  - S: STORE.
  - B: BRANCH, bit 0 = 0.
  - U: LUI/AUIPC, low 12 bits = 0.
  - J: JAL, bit 0 = 0.
  - Shift-immediates use instr[24:20], zero-extended.
- Unknown opcode: `illegal`=1, `alu_ctl`=ADD, `reg_write`=0, other fields decoded as an I-type.
- An illegal bundle is still delivered, with `out_valid`=1; it is not dropped.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is presented on `out_*` after edge N.
- Acceptance occurs when `in_valid && in_ready`.
- `in_ready = !out_valid || out_ready`, combinational. Full throughput of one per cycle is sustained with `out_ready` held high.
- While `out_valid && !out_ready`, all `out_*` are stable and no new instruction is captured.
- Simultaneous accept and drain: the register loads the new instruction and `out_valid` stays 1.
- `flush` has priority over accept:
  - next `out_valid`=0 and the incoming instruction is discarded;
  - `in_ready` is unaffected by `flush` in the same cycle.
- Reset values, asynchronous and held throughout reset:
  - `out_valid`=0, `out_alu_ctl`=0000, `out_a_sel`=00, `out_b_sel`=0;
  - `out_rs1`/`out_rs2`/`out_rd`=0, `out_imm`=0, `out_reg_write`=0, `out_illegal`=0, `out_pc`=0.
- Reset mid-transfer loses the held instruction. After deassertion, the first accept occurs on the first edge with `in_valid`=1.

## Structure
- Shared package `alu_pkg`:
  - ALU opcode constants (`ALU_ADD` … `ALU_XOR`), shared with the ALU;
  - RV32I opcode constants;
  - A-select constants.
- Sub-module `alu_decode_comb`: purely combinational instruction → bundle decoder.
- Top level: handshake plus the output register.

## Test plan
- `0x002081B3` (add x3,x1,x2) → next cycle: `alu_ctl`=0000, rs1=1, rs2=2, rd=3, `b_sel`=0, `reg_write`=1, `illegal`=0.
- `0x402081B3` (sub) → `alu_ctl`=0001; `0xFFF00093` (addi x1,x0,-1) → `imm`=0xFFFFFFFF, `b_sel`=1, `alu_ctl`=0000.
- `0x0020E463` (bltu x1,x2,+8) → `alu_ctl`=1001, `imm`=0x00000008, `a_sel`=00, `b_sel`=0, `reg_write`=0.
- `0x4010D093` (srai) → `illegal`=1, `alu_ctl`=0000; opcode 0x7F → `illegal`=1.
- Back-to-back stream with `out_ready` low for 2 cycles → `in_ready`=0 and `out_*` frozen; no instruction lost or duplicated; order preserved.
- `flush` with `in_valid`=1 → next `out_valid`=0. Reset asserted while `out_valid`=1 → all outputs at reset values immediately, without waiting for a clock edge.
